// File: rtl/receptor_comandos_drone.sv
// UART 8N1 command receiver: decodes operator keystrokes into held control levels
// for the drone simulator (vertical, horizontal, confirm, start).
module receptor_comandos_drone #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HOLD_CYCLES  = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [1:0] controle_vertical,
    output logic [1:0] controle_horizontal,
    output logic       confirma,
    output logic       iniciar,
    output logic       comando_valido,
    output logic       erro,
    output logic [7:0] db_dado,
    output logic [3:0] db_estado
);

    localparam logic [3:0] OCIOSO      = 4'd0;
    localparam logic [3:0] INICIO      = 4'd1;
    localparam logic [3:0] DADOS       = 4'd2;
    localparam logic [3:0] PARADA      = 4'd3;
    localparam logic [3:0] DECODIFICA  = 4'd4;
    localparam logic [3:0] ESPERA_ALTO = 4'd5;

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] BIT_FIM  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MEIO_FIM = CW'((CLKS_PER_BIT / 2) - 1);
    localparam logic [HW-1:0] HOLD_INI = HW'(HOLD_CYCLES);

    logic          rxMeta_q, rxSync_q, rxPrev_q;
    logic [1:0]    aquece_q;
    logic [3:0]    estado_q, estado_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dado_q, dado_d;
    logic [1:0]    vert_q, vert_d, hor_q, hor_d;
    logic          conf_q, conf_d, ini_q, ini_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          valido_q, valido_d, erro_q, erro_d;
    logic          descida, erroQuadro;
    logic          conhecido, cancela;
    logic [1:0]    novoVert, novoHor;
    logic          novoConf, novoIni;

    // Edge detection is armed only once the previous sample is a real line value,
    // so a line held low out of reset never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
            aquece_q <= 2'd0;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
            if (aquece_q != 2'd3)
                aquece_q <= aquece_q + 2'd1;
        end
    end

    assign descida = (aquece_q == 2'd3) && rxPrev_q && !rxSync_q;

    always_comb begin
        estado_d   = estado_q;
        baud_d     = baud_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        dado_d     = dado_q;
        erroQuadro = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (descida) begin
                    estado_d = INICIO;
                    baud_d   = '0;
                    bitCnt_d = 3'd0;
                end
            end
            INICIO: begin
                if (baud_q == MEIO_FIM) begin
                    baud_d   = '0;
                    estado_d = rxSync_q ? OCIOSO : DADOS;
                end else
                    baud_d = baud_q + CW'(1);
            end
            DADOS: begin
                if (baud_q == BIT_FIM) begin
                    baud_d   = '0;
                    shift_d  = {rxSync_q, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7)
                        estado_d = PARADA;
                end else
                    baud_d = baud_q + CW'(1);
            end
            PARADA: begin
                if (baud_q == BIT_FIM) begin
                    baud_d = '0;
                    if (rxSync_q) begin
                        dado_d   = shift_q;
                        estado_d = DECODIFICA;
                    end else begin
                        erroQuadro = 1'b1;
                        estado_d   = ESPERA_ALTO;
                    end
                end else
                    baud_d = baud_q + CW'(1);
            end
            DECODIFICA:  estado_d = OCIOSO;
            ESPERA_ALTO: if (rxSync_q) estado_d = OCIOSO;
            default:     estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        conhecido = 1'b1;
        cancela   = 1'b0;
        novoVert  = 2'b00;
        novoHor   = 2'b00;
        novoConf  = 1'b0;
        novoIni   = 1'b0;
        case (dado_q)
            8'h77, 8'h57: novoVert = 2'b01;
            8'h73, 8'h53: novoVert = 2'b10;
            8'h64, 8'h44: novoHor  = 2'b01;
            8'h61, 8'h41: novoHor  = 2'b10;
            8'h63, 8'h43: novoConf = 1'b1;
            8'h69, 8'h49: novoIni  = 1'b1;
            8'h78, 8'h58: cancela  = 1'b1;
            default:      conhecido = 1'b0;
        endcase
    end

    // A decoded command overrides the expiry of the running hold, so a command
    // landing on the last hold cycle replaces the value without a gap.
    always_comb begin
        vert_d   = vert_q;
        hor_d    = hor_q;
        conf_d   = conf_q;
        ini_d    = ini_q;
        hold_d   = hold_q;
        valido_d = 1'b0;
        erro_d   = erroQuadro;
        if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) begin
                vert_d = 2'b00;
                hor_d  = 2'b00;
                conf_d = 1'b0;
                ini_d  = 1'b0;
            end
        end
        if (estado_q == DECODIFICA) begin
            if (conhecido) begin
                vert_d   = novoVert;
                hor_d    = novoHor;
                conf_d   = novoConf;
                ini_d    = novoIni;
                hold_d   = cancela ? '0 : HOLD_INI;
                valido_d = 1'b1;
            end else
                erro_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            baud_q   <= '0;
            bitCnt_q <= 3'd0;
            shift_q  <= 8'h00;
            dado_q   <= 8'h00;
            vert_q   <= 2'b00;
            hor_q    <= 2'b00;
            conf_q   <= 1'b0;
            ini_q    <= 1'b0;
            hold_q   <= '0;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            baud_q   <= baud_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            dado_q   <= dado_d;
            vert_q   <= vert_d;
            hor_q    <= hor_d;
            conf_q   <= conf_d;
            ini_q    <= ini_d;
            hold_q   <= hold_d;
            valido_q <= valido_d;
            erro_q   <= erro_d;
        end
    end

    assign controle_vertical   = vert_q;
    assign controle_horizontal = hor_q;
    assign confirma            = conf_q;
    assign iniciar             = ini_q;
    assign comando_valido      = valido_q;
    assign erro                = erro_q;
    assign db_dado             = dado_q;
    assign db_estado           = estado_q;

endmodule

// File: tb/tb_receptor_comandos_drone.sv
// Directed bench for receptor_comandos_drone: table of command bytes plus hand-written
// sequences for reset, replacement/cancel, framing error, break and glitch cases.
module tb_receptor_comandos_drone;

    localparam int CPB = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic [1:0] vert, hor, vertL, horL;
    logic       conf, ini, valido, erro, confL, iniL, validoL, erroL;
    logic [7:0] dado, dadoL;
    logic [3:0] estado, estadoL;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        int vu, vd, hf, hb, cf, in, va, er, bo, mu, enz, e5, lu, ld, lva, ler;
    } cont_t;

    typedef struct {
        logic [7:0] dado;
        int vu, vd, hf, hb, cf, in, va, er;
    } vetor_t;

    cont_t  acc = '{default: 0};
    vetor_t vetores [9];

    receptor_comandos_drone #(.CLKS_PER_BIT(CPB), .HOLD_CYCLES(20)) dut (
        .clock(clock), .reset(reset), .rx(rx),
        .controle_vertical(vert), .controle_horizontal(hor),
        .confirma(conf), .iniciar(ini),
        .comando_valido(valido), .erro(erro),
        .db_dado(dado), .db_estado(estado)
    );

    // Long-hold copy so a replacement can land while the previous hold is still running.
    receptor_comandos_drone #(.CLKS_PER_BIT(CPB), .HOLD_CYCLES(120)) dutLongo (
        .clock(clock), .reset(reset), .rx(rx),
        .controle_vertical(vertL), .controle_horizontal(horL),
        .confirma(confL), .iniciar(iniL),
        .comando_valido(validoL), .erro(erroL),
        .db_dado(dadoL), .db_estado(estadoL)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        acc.vu  += int'(vert == 2'b01);
        acc.vd  += int'(vert == 2'b10);
        acc.hf  += int'(hor == 2'b01);
        acc.hb  += int'(hor == 2'b10);
        acc.cf  += int'(conf);
        acc.in  += int'(ini);
        acc.va  += int'(valido);
        acc.er  += int'(erro);
        acc.bo  += int'(valido && erro);
        acc.mu  += int'((int'(vert != 2'b00) + int'(hor != 2'b00) + int'(conf) + int'(ini)) > 1);
        acc.enz += int'(estado != 4'd0);
        acc.e5  += int'(estado == 4'd5);
        acc.lu  += int'(vertL == 2'b01);
        acc.ld  += int'(vertL == 2'b10);
        acc.lva += int'(validoL);
        acc.ler += int'(erroL);
    end

    function automatic cont_t delta(input cont_t a, input cont_t b);
        cont_t d;
        d.vu = b.vu - a.vu;   d.vd = b.vd - a.vd;   d.hf = b.hf - a.hf;
        d.hb = b.hb - a.hb;   d.cf = b.cf - a.cf;   d.in = b.in - a.in;
        d.va = b.va - a.va;   d.er = b.er - a.er;   d.bo = b.bo - a.bo;
        d.mu = b.mu - a.mu;   d.enz = b.enz - a.enz; d.e5 = b.e5 - a.e5;
        d.lu = b.lu - a.lu;   d.ld = b.ld - a.ld;   d.lva = b.lva - a.lva;
        d.ler = b.ler - a.ler;
        return d;
    endfunction

    task automatic checkOutput(input string nome, input int atual, input int esperado);
        nChecks++;
        if (atual == esperado)
            nPass++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", nome, atual, esperado);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Called just after a rising edge; each bit lasts exactly CPB cycles.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        logic [9:0] quadro;
        quadro = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = quadro[i];
            idle(CPB);
        end
    endtask

    initial begin
        cont_t base, d;
        logic [7:0] parcial;

        vetores[0] = '{8'h77, 20, 0, 0, 0, 0, 0, 1, 0};
        vetores[1] = '{8'h73, 0, 20, 0, 0, 0, 0, 1, 0};
        vetores[2] = '{8'h64, 0, 0, 20, 0, 0, 0, 1, 0};
        vetores[3] = '{8'h61, 0, 0, 0, 20, 0, 0, 1, 0};
        vetores[4] = '{8'h63, 0, 0, 0, 0, 20, 0, 1, 0};
        vetores[5] = '{8'h69, 0, 0, 0, 0, 0, 20, 1, 0};
        vetores[6] = '{8'h57, 20, 0, 0, 0, 0, 0, 1, 0};
        vetores[7] = '{8'h44, 0, 0, 20, 0, 0, 0, 1, 0};
        vetores[8] = '{8'h5A, 0, 0, 0, 0, 0, 0, 0, 1};

        rx    = 1'b1;
        reset = 1'b1;
        idle(3);
        checkOutput("reset vertical", int'(vert), 0);
        checkOutput("reset horizontal", int'(hor), 0);
        checkOutput("reset confirma", int'(conf), 0);
        checkOutput("reset iniciar", int'(ini), 0);
        checkOutput("reset valido", int'(valido), 0);
        checkOutput("reset erro", int'(erro), 0);
        checkOutput("reset db_dado", int'(dado), 0);
        checkOutput("reset db_estado", int'(estado), 0);
        reset = 1'b0;
        idle(5);

        $display("[TB] reset mid-frame");
        parcial = 8'h77;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = parcial[i];
            idle(CPB);
        end
        rx = parcial[3];
        idle(3);
        reset = 1'b1;
        idle(3);
        checkOutput("abort db_estado", int'(estado), 0);
        reset = 1'b0;
        base = acc;
        idle(6);
        rx = 1'b1;
        idle(10);
        d = delta(base, acc);
        checkOutput("low-out-of-reset estado", d.enz, 0);
        checkOutput("abort valido", d.va, 0);
        checkOutput("abort erro", d.er, 0);
        base = acc;
        applyStimulus(8'h64, 1'b1);
        idle(30);
        d = delta(base, acc);
        checkOutput("after reset horizontal fwd", d.hf, 20);
        checkOutput("after reset others", d.vu + d.vd + d.hb + d.cf + d.in, 0);
        checkOutput("after reset valido", d.va, 1);
        checkOutput("after reset db_dado", int'(dado), 8'h64);

        $display("[TB] command table");
        for (int k = 0; k < 9; k++) begin
            base = acc;
            applyStimulus(vetores[k].dado, 1'b1);
            idle(30);
            d = delta(base, acc);
            checkOutput($sformatf("v%0d up", k), d.vu, vetores[k].vu);
            checkOutput($sformatf("v%0d down", k), d.vd, vetores[k].vd);
            checkOutput($sformatf("v%0d fwd", k), d.hf, vetores[k].hf);
            checkOutput($sformatf("v%0d back", k), d.hb, vetores[k].hb);
            checkOutput($sformatf("v%0d confirma", k), d.cf, vetores[k].cf);
            checkOutput($sformatf("v%0d iniciar", k), d.in, vetores[k].in);
            checkOutput($sformatf("v%0d valido", k), d.va, vetores[k].va);
            checkOutput($sformatf("v%0d erro", k), d.er, vetores[k].er);
            checkOutput($sformatf("v%0d overlap", k), d.mu + d.bo, 0);
            checkOutput($sformatf("v%0d db_estado", k), int'(estado), 0);
            checkOutput($sformatf("v%0d db_dado", k), int'(dado), int'(vetores[k].dado));
        end

        $display("[TB] replace and cancel");
        idle(130);
        base = acc;
        applyStimulus(8'h57, 1'b1);
        idle(2);
        applyStimulus(8'h53, 1'b1);
        idle(2);
        applyStimulus(8'h78, 1'b1);
        @(negedge clock);
        checkOutput("cancel long controls", int'(vertL) + int'(horL) + int'(confL) + int'(iniL), 0);
        idle(30);
        d = delta(base, acc);
        checkOutput("long up run", d.lu, 82);
        checkOutput("long down run", d.ld, 82);
        checkOutput("short up", d.vu, 20);
        checkOutput("short down", d.vd, 20);
        checkOutput("replace overlap", d.mu + d.bo, 0);

        $display("[TB] framing error and break");
        base = acc;
        applyStimulus(8'h77, 1'b0);
        idle(50);
        checkOutput("break db_estado", int'(estado), 5);
        rx = 1'b1;
        idle(6);
        d = delta(base, acc);
        checkOutput("framing erro", d.er, 1);
        checkOutput("framing valido", d.va, 0);
        checkOutput("framing controls", d.vu + d.vd + d.hf + d.hb + d.cf + d.in, 0);
        checkOutput("break cycles", d.e5, 54);
        checkOutput("after break db_estado", int'(estado), 0);
        checkOutput("framing db_dado", int'(dado), 8'h78);

        $display("[TB] glitch and unknown byte");
        idle(5);
        base = acc;
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(12);
        d = delta(base, acc);
        checkOutput("glitch valido", d.va, 0);
        checkOutput("glitch erro", d.er, 0);
        checkOutput("glitch busy cycles", d.enz, 4);
        base = acc;
        applyStimulus(8'h41, 1'b1);
        idle(2);
        applyStimulus(8'h5A, 1'b1);
        idle(30);
        d = delta(base, acc);
        checkOutput("A back", d.hb, 20);
        checkOutput("A erro", d.er, 1);
        checkOutput("A valido", d.va, 1);
        checkOutput("A others", d.vu + d.vd + d.hf + d.cf + d.in + d.bo, 0);
        checkOutput("long valido", d.lva, 1);
        checkOutput("long erro", d.ler, 1);
        checkOutput("long db_dado", int'(dadoL), 8'h5A);
        checkOutput("long db_estado", int'(estadoL), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
